// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: result-select encodings,
// the link register index and the squash FSM state encoding.
package wb_stage_pkg;

    typedef enum logic [1:0] {
        SEL_ALU_LO = 2'b00,
        SEL_LO     = 2'b01,
        SEL_HI     = 2'b10,
        SEL_SHIFT  = 2'b11
    } super_sel_e;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic {
        SQ_IDLE   = 1'b0,
        SQ_SQUASH = 1'b1
    } sq_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// Write-back stage bundle: instruction inputs from the pipeline plus the
// register-file, HI/LO, redirect and retire outputs.
interface wb_stage_if;
    logic        validW;
    logic        multu_enW;
    logic        jr_selW;
    logic        dm2regW;
    logic        jumpW;
    logic        jal_selW;
    logic        we_regW;
    logic [1:0]  super_selW;
    logic [31:0] pc_plus_4W;
    logic [31:0] alu_paW;
    logic [31:0] rd_dmW;
    logic [31:0] shiftyW;
    logic [31:0] jtaW;
    logic [63:0] alu_outW;
    logic [4:0]  rf_waW;

    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        squashing;
    logic [31:0] retire_cnt;

    modport master (
        output validW, multu_enW, jr_selW, dm2regW, jumpW, jal_selW, we_regW,
               super_selW, pc_plus_4W, alu_paW, rd_dmW, shiftyW, jtaW,
               alu_outW, rf_waW,
        input  rf_we, rf_wa, rf_wd, hi_q, lo_q, redirect, redirect_pc,
               squashing, retire_cnt
    );

    modport slave (
        input  validW, multu_enW, jr_selW, dm2regW, jumpW, jal_selW, we_regW,
               super_selW, pc_plus_4W, alu_paW, rd_dmW, shiftyW, jtaW,
               alu_outW, rf_waW,
        output rf_we, rf_wa, rf_wd, hi_q, lo_q, redirect, redirect_pc,
               squashing, retire_cnt
    );
endinterface

// File: rtl/wb_stage_squash_ctrl.sv
// Squash window controller: after a trigger, holds active for SQUASH_DEPTH
// cycles; triggers arriving inside the window are ignored.
//   state     | meaning
//   SQ_IDLE   | no squash window, trigger accepted
//   SQ_SQUASH | window open, cnt_q counts remaining cycles down to 0
module squash_ctrl
    import wb_stage_pkg::*;
#(
    parameter int SQUASH_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger,
    output logic active
);

    localparam logic [3:0] DEPTH = 4'(SQUASH_DEPTH);

    sq_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SQ_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            SQ_IDLE: begin
                if (trigger) begin
                    state_d = SQ_SQUASH;
                    cnt_d   = DEPTH;
                end
            end
            SQ_SQUASH: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = SQ_IDLE;
                end
            end
            default: begin
                state_d = SQ_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign active = (state_q == SQ_SQUASH);

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: register-file write mux, HI/LO registers, jump redirect
// with post-redirect squash window, and committed-instruction counter.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int SQUASH_DEPTH = 4
) (
    input logic      clk,
    input logic      rst,
    wb_stage_if.slave wb
);

    logic        squashing;
    logic        ev;
    logic        redirect;
    logic [31:0] hi_val_q, hi_val_d;
    logic [31:0] lo_val_q, lo_val_d;
    logic [31:0] retire_q, retire_d;
    logic [31:0] rf_wd;

    // rst is folded in so the combinational outputs stay low during reset
    assign ev       = wb.validW & ~squashing & ~rst;
    assign redirect = ev & (wb.jumpW | wb.jr_selW);

    squash_ctrl #(
        .SQUASH_DEPTH(SQUASH_DEPTH)
    ) u_squash (
        .clk    (clk),
        .rst    (rst),
        .trigger(redirect),
        .active (squashing)
    );

    always_comb begin
        rf_wd = wb.alu_outW[31:0];
        if (wb.jal_selW) begin
            rf_wd = wb.pc_plus_4W;
        end else if (wb.dm2regW) begin
            rf_wd = wb.rd_dmW;
        end else begin
            unique case (super_sel_e'(wb.super_selW))
                SEL_ALU_LO: rf_wd = wb.alu_outW[31:0];
                SEL_LO:     rf_wd = lo_val_q;
                SEL_HI:     rf_wd = hi_val_q;
                SEL_SHIFT:  rf_wd = wb.shiftyW;
                default:    rf_wd = wb.alu_outW[31:0];
            endcase
        end
    end

    always_comb begin
        hi_val_d = hi_val_q;
        lo_val_d = lo_val_q;
        retire_d = retire_q;
        if (ev && wb.multu_enW) begin
            hi_val_d = wb.alu_outW[63:32];
            lo_val_d = wb.alu_outW[31:0];
        end
        if (ev) begin
            retire_d = retire_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_val_q <= 32'd0;
            lo_val_q <= 32'd0;
            retire_q <= 32'd0;
        end else begin
            hi_val_q <= hi_val_d;
            lo_val_q <= lo_val_d;
            retire_q <= retire_d;
        end
    end

    assign wb.rf_wd       = rf_wd;
    assign wb.rf_wa       = wb.jal_selW ? REG_RA : wb.rf_waW;
    assign wb.rf_we       = ev & (wb.we_regW | wb.jal_selW);
    assign wb.hi_q        = hi_val_q;
    assign wb.lo_q        = lo_val_q;
    assign wb.redirect    = redirect;
    assign wb.redirect_pc = wb.jr_selW ? wb.alu_paW : wb.jtaW;
    assign wb.squashing   = squashing;
    assign wb.retire_cnt  = retire_q;

endmodule
